// File: rtl/step_pkg.sv
// rtl/step_pkg.sv - coil pattern constants, decoder state enum and pattern decode helper
package step_pkg;

  // Full-step coil patterns, shared with the drive-side FSM
  localparam logic [3:0] P0 = 4'b1100;
  localparam logic [3:0] P1 = 4'b0110;
  localparam logic [3:0] P2 = 4'b0011;
  localparam logic [3:0] P3 = 4'b1001;

  typedef enum logic [1:0] {
    UNSYNC = 2'd0,
    TRACK  = 2'd1,
    FAULT  = 2'd2
  } state_t;

  typedef struct packed {
    logic       legal;
    logic [1:0] idx;
  } decode_t;

  // Map a coil pattern to its phase index; any of the other 12 codes is illegal
  function automatic decode_t decode_phases(input logic [3:0] pat);
    decode_t d;
    d.legal = 1'b1;
    d.idx   = 2'd0;
    case (pat)
      P0:      d.idx = 2'd0;
      P1:      d.idx = 2'd1;
      P2:      d.idx = 2'd2;
      P3:      d.idx = 2'd3;
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/phase_filter.sv
// rtl/phase_filter.sv - qualifies the registered sample once it has held for FILTER_LEN samples
module phase_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic [3:0] i_phases,
  input  logic [3:0] i_sample,
  output logic       o_tvalid
);

  localparam int CNT_W = $clog2(FILTER_LEN + 1);

  // Run length of the value held in the sample register, counted as it is loaded
  logic [CNT_W-1:0] r_run;

  // A new value entering the sample register restarts the run; the count saturates
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_run <= '0;
    end else if (i_phases != i_sample) begin
      r_run <= CNT_W'(1);
    end else if (r_run < CNT_W'(FILTER_LEN)) begin
      r_run <= r_run + CNT_W'(1);
    end
  end

  assign o_tvalid = (r_run >= CNT_W'(FILTER_LEN));

endmodule

// File: rtl/step_decoder.sv
// rtl/step_decoder.sv - stepper coil pattern decoder (optional glitch filter: STEP_DECODER_GLITCH_FILTER_EN)
module step_decoder
  import step_pkg::*;
#(
  parameter int POS_W      = 16,
  parameter int FILTER_LEN = 4
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic [3:0]              i_phases,
  input  logic                    i_clear_fault,
  input  logic                    i_zero_pos,
  output logic                    o_step_pulse,
  output logic                    o_step_dir,
  output logic signed [POS_W-1:0] o_position,
  output logic [1:0]              o_phase_idx,
  output logic                    o_synced,
  output logic                    o_fault
);

  localparam logic signed [POS_W-1:0] POS_ONE = POS_W'(1);

  logic [3:0]              r_sample;
  state_t                  r_state;
  logic                    r_step_pulse;
  logic                    r_step_dir;
  logic signed [POS_W-1:0] r_position;
  logic [1:0]              r_phase_idx;
  logic                    r_synced;
  logic                    r_fault;
  logic                    w_eval_valid;
  decode_t                 w_dec;

  // Sample stage: decisions are only ever made on the registered copy of the coils
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_sample <= 4'b0000;
    end else begin
      r_sample <= i_phases;
    end
  end

`ifdef STEP_DECODER_GLITCH_FILTER_EN
  phase_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_phase_filter (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_phases (i_phases),
    .i_sample (r_sample),
    .o_tvalid (w_eval_valid)
  );
`else
  // Unfiltered: every registered sample is evaluated (true for any sane FILTER_LEN)
  assign w_eval_valid = (FILTER_LEN > 0);
`endif

  assign w_dec = decode_phases(r_sample);

  // Tracking FSM; synced/fault are registered alongside the state transitions
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state      <= UNSYNC;
      r_step_pulse <= 1'b0;
      r_step_dir   <= 1'b0;
      r_position   <= '0;
      r_phase_idx  <= 2'd0;
      r_synced     <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_step_pulse <= 1'b0;
      case (r_state)
        UNSYNC: begin
          if (w_eval_valid && w_dec.legal) begin
            r_state     <= TRACK;
            r_phase_idx <= w_dec.idx;
            r_synced    <= 1'b1;
          end
        end
        TRACK: begin
          if (w_eval_valid) begin
            if (!w_dec.legal || (w_dec.idx == r_phase_idx + 2'd2)) begin
              r_state  <= FAULT;
              r_synced <= 1'b0;
              r_fault  <= 1'b1;
            end else if (w_dec.idx == r_phase_idx + 2'd1) begin
              r_step_pulse <= 1'b1;
              r_step_dir   <= 1'b1;
              r_position   <= r_position + POS_ONE;
              r_phase_idx  <= w_dec.idx;
            end else if (w_dec.idx == r_phase_idx - 2'd1) begin
              r_step_pulse <= 1'b1;
              r_step_dir   <= 1'b0;
              r_position   <= r_position - POS_ONE;
              r_phase_idx  <= w_dec.idx;
            end
          end
        end
        FAULT: begin
          if (i_clear_fault) begin
            r_state <= UNSYNC;
            r_fault <= 1'b0;
          end
        end
        default: begin
          r_state  <= UNSYNC;
          r_synced <= 1'b0;
          r_fault  <= 1'b0;
        end
      endcase
      // Zeroing wins over any step taken on the same edge
      if (i_zero_pos) begin
        r_position <= '0;
      end
    end
  end

  assign o_step_pulse = r_step_pulse;
  assign o_step_dir   = r_step_dir;
  assign o_position   = r_position;
  assign o_phase_idx  = r_phase_idx;
  assign o_synced     = r_synced;
  assign o_fault      = r_fault;

endmodule

// File: tb/tb_step_decoder.sv
// tb/tb_step_decoder.sv - self-checking bench for step_decoder with a behavioural reference model
module tb_step_decoder;

  localparam int POS_W      = 16;
  localparam int FILTER_LEN = 4;
`ifdef STEP_DECODER_GLITCH_FILTER_EN
  localparam int EXTRA = FILTER_LEN - 1;
  localparam int NHIST = FILTER_LEN;
`else
  localparam int EXTRA = 0;
  localparam int NHIST = 1;
`endif
  localparam int M_UNSYNC = 0;
  localparam int M_TRACK  = 1;
  localparam int M_FAULT  = 2;
  localparam int POS_SPAN = 1 << POS_W;
  localparam int POS_MAX  = (1 << (POS_W - 1)) - 1;
  localparam int POS_MIN  = -(1 << (POS_W - 1));

  logic                    clk;
  logic                    rst;
  logic [3:0]              phases;
  logic                    clr;
  logic                    zero;
  logic                    o_step_pulse;
  logic                    o_step_dir;
  logic signed [POS_W-1:0] o_position;
  logic [1:0]              o_phase_idx;
  logic                    o_synced;
  logic                    o_fault;

  step_decoder #(
    .POS_W      (POS_W),
    .FILTER_LEN (FILTER_LEN)
  ) dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_phases      (phases),
    .i_clear_fault (clr),
    .i_zero_pos    (zero),
    .o_step_pulse  (o_step_pulse),
    .o_step_dir    (o_step_dir),
    .o_position    (o_position),
    .o_phase_idx   (o_phase_idx),
    .o_synced      (o_synced),
    .o_fault       (o_fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [3:0] pat [4] = '{4'b1100, 4'b0110, 4'b0011, 4'b1001};

  int         errors = 0;
  int         checks = 0;
  int         mism = 0;
  int         first_mism = -1;
  int         d_pulses = 0;
  int         cyc = 0;

  int         m_state = M_UNSYNC;
  int         m_idx = 0;
  int         m_pos = 0;
  bit         m_dir = 1'b0;
  bit         m_pulse = 1'b0;
  logic [3:0] hist[$];

  function automatic int pattern_index(input logic [3:0] p);
    for (int k = 0; k < 4; k++) if (pat[k] == p) return k;
    return -1;
  endfunction

  function automatic int wrap_pos(input int v);
    if (v > POS_MAX) return v - POS_SPAN;
    if (v < POS_MIN) return v + POS_SPAN;
    return v;
  endfunction

  // Reference behaviour for one rising edge, from the pattern rules
  task automatic model_edge();
    bit elig;
    int k;
    if (rst) begin
      m_state = M_UNSYNC; m_idx = 0; m_pos = 0; m_dir = 1'b0; m_pulse = 1'b0;
      hist.delete();
      return;
    end
    m_pulse = 1'b0;
    elig = (hist.size() >= NHIST);
    if (elig) for (int j = 0; j < hist.size(); j++) if (hist[j] != hist[hist.size()-1]) elig = 1'b0;
    if (m_state == M_FAULT) begin
      if (clr) m_state = M_UNSYNC;
    end else if (elig) begin
      k = pattern_index(hist[hist.size()-1]);
      if (m_state == M_UNSYNC) begin
        if (k >= 0) begin m_state = M_TRACK; m_idx = k; end
      end else if (k < 0 || k == (m_idx + 2) % 4) begin
        m_state = M_FAULT;
      end else if (k == (m_idx + 1) % 4) begin
        m_pulse = 1'b1; m_dir = 1'b1; m_pos = wrap_pos(m_pos + 1); m_idx = k;
      end else if (k == (m_idx + 3) % 4) begin
        m_pulse = 1'b1; m_dir = 1'b0; m_pos = wrap_pos(m_pos - 1); m_idx = k;
      end
    end
    if (zero) m_pos = 0;
    hist.push_back(phases);
    if (hist.size() > NHIST) void'(hist.pop_front());
  endtask

  task automatic tick();
    logic [POS_W-1:0] exp_pos;
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    if (o_step_pulse === 1'b1) d_pulses++;
    exp_pos = m_pos[POS_W-1:0];
    if (o_step_pulse !== m_pulse || o_step_dir !== m_dir || o_position !== exp_pos ||
        o_phase_idx !== m_idx[1:0] || o_synced !== (m_state == M_TRACK) || o_fault !== (m_state == M_FAULT)) begin
      mism++;
      if (first_mism < 0) first_mism = cyc;
    end
  endtask

  task automatic apply(input logic [3:0] p, input int n);
    phases = p;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; phases = 4'b0000; clr = 1'b0; zero = 1'b0;
    tick(); tick();
    rst = 1'b0;
    mism = 0; first_mism = -1; d_pulses = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; phases = 4'b0110; clr = 1'b1; zero = 1'b0;
    tick(); tick();
    checks++; if (o_step_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse got=%b exp=0", o_step_pulse); end
    checks++; if (o_step_dir !== 1'b0) begin errors++; $display("FAIL reset_dir got=%b exp=0", o_step_dir); end
    checks++; if (o_position !== 16'sd0) begin errors++; $display("FAIL reset_pos got=%0d exp=0", o_position); end
    checks++; if (o_phase_idx !== 2'd0) begin errors++; $display("FAIL reset_idx got=%0d exp=0", o_phase_idx); end
    checks++; if (o_synced !== 1'b0) begin errors++; $display("FAIL reset_synced got=%b exp=0", o_synced); end
    checks++; if (o_fault !== 1'b0) begin errors++; $display("FAIL reset_fault got=%b exp=0", o_fault); end
    rst = 1'b0; clr = 1'b0;
  endtask

  task automatic test_forward();
    do_reset();
    apply(4'b1100, 8); apply(4'b0110, 8); apply(4'b0011, 8); apply(4'b1001, 8); apply(4'b1100, 8);
    checks++; if (d_pulses != 4) begin errors++; $display("FAIL fwd_pulses got=%0d exp=4", d_pulses); end
    checks++; if (o_step_dir !== 1'b1) begin errors++; $display("FAIL fwd_dir got=%b exp=1", o_step_dir); end
    checks++; if (o_position !== 16'sd4) begin errors++; $display("FAIL fwd_pos got=%0d exp=4", o_position); end
    checks++; if (o_phase_idx !== 2'd0) begin errors++; $display("FAIL fwd_idx got=%0d exp=0", o_phase_idx); end
    checks++; if (mism != 0) begin errors++; $display("FAIL fwd_model got=%0d bad cycles (first %0d) exp=0", mism, first_mism); end
  endtask

  task automatic test_reverse();
    do_reset();
    apply(4'b1100, 8);
    d_pulses = 0;
    apply(4'b1001, 8); apply(4'b0011, 8);
    checks++; if (d_pulses != 2) begin errors++; $display("FAIL rev_pulses got=%0d exp=2", d_pulses); end
    checks++; if (o_step_dir !== 1'b0) begin errors++; $display("FAIL rev_dir got=%b exp=0", o_step_dir); end
    checks++; if (o_position !== -16'sd2) begin errors++; $display("FAIL rev_pos got=%0d exp=-2", o_position); end
    checks++; if (mism != 0) begin errors++; $display("FAIL rev_model got=%0d bad cycles (first %0d) exp=0", mism, first_mism); end
  endtask

  task automatic test_fault();
    do_reset();
    apply(4'b1100, 8);
    d_pulses = 0;
    apply(4'b0011, 8);
    checks++; if (o_fault !== 1'b1) begin errors++; $display("FAIL fault_set got=%b exp=1", o_fault); end
    checks++; if (o_synced !== 1'b0) begin errors++; $display("FAIL fault_synced got=%b exp=0", o_synced); end
    checks++; if (o_position !== 16'sd0 || d_pulses != 0) begin errors++; $display("FAIL fault_pos got=%0d/%0d pulses exp=0/0", o_position, d_pulses); end
    clr = 1'b1; phases = 4'b0110;
    tick();
    clr = 1'b0;
    checks++; if (o_fault !== 1'b0 || o_synced !== 1'b0) begin errors++; $display("FAIL fault_clear got=f%b s%b exp=f0 s0", o_fault, o_synced); end
    apply(4'b0110, 8);
    checks++; if (o_synced !== 1'b1 || o_phase_idx !== 2'd1) begin errors++; $display("FAIL fault_resync got=s%b idx%0d exp=s1 idx1", o_synced, o_phase_idx); end
    checks++; if (d_pulses != 0) begin errors++; $display("FAIL fault_resync_pulse got=%0d exp=0", d_pulses); end
    checks++; if (mism != 0) begin errors++; $display("FAIL fault_model got=%0d bad cycles (first %0d) exp=0", mism, first_mism); end
  endtask

  task automatic test_latency();
    int n;
    do_reset();
    apply(4'b1100, 8);
    d_pulses = 0;
    phases = 4'b0110;
    n = 0;
    do begin tick(); n++; end while (o_step_pulse !== 1'b1 && n < 20);
    checks++; if (n != 2 + EXTRA) begin errors++; $display("FAIL latency got=%0d edges exp=%0d", n, 2 + EXTRA); end
    repeat (8) tick();
    checks++; if (d_pulses != 1) begin errors++; $display("FAIL single_pulse got=%0d exp=1", d_pulses); end
    // Zero in the very edge that takes the next step
    phases = 4'b0011;
    repeat (1 + EXTRA) tick();
    zero = 1'b1;
    tick();
    zero = 1'b0;
    checks++; if (o_step_pulse !== 1'b1) begin errors++; $display("FAIL zero_step_pulse got=%b exp=1", o_step_pulse); end
    checks++; if (o_position !== 16'sd0) begin errors++; $display("FAIL zero_step_pos got=%0d exp=0", o_position); end
    checks++; if (o_phase_idx !== 2'd2) begin errors++; $display("FAIL zero_step_idx got=%0d exp=2", o_phase_idx); end
  endtask

`ifndef STEP_DECODER_GLITCH_FILTER_EN
  task automatic test_wrap();
    do_reset();
    apply(pat[0], 4);
    for (int s = 1; s <= POS_MAX; s++) begin phases = pat[s % 4]; tick(); end
    tick();
    checks++; if (o_position !== 16'sh7FFF) begin errors++; $display("FAIL wrap_preload got=%0d exp=32767", o_position); end
    apply(pat[(POS_MAX + 1) % 4], 3);
    checks++; if (o_position !== 16'sh8000) begin errors++; $display("FAIL wrap_pos got=%0d exp=-32768", o_position); end
    checks++; if (mism != 0) begin errors++; $display("FAIL wrap_model got=%0d bad cycles (first %0d) exp=0", mism, first_mism); end
  endtask
`else
  task automatic test_glitch();
    do_reset();
    apply(4'b1100, 8);
    d_pulses = 0;
    apply(4'b1111, 2);
    apply(4'b1100, 8);
    checks++; if (o_fault !== 1'b0 || o_synced !== 1'b1) begin errors++; $display("FAIL glitch_fault got=f%b s%b exp=f0 s1", o_fault, o_synced); end
    checks++; if (d_pulses != 0) begin errors++; $display("FAIL glitch_pulse got=%0d exp=0", d_pulses); end
    checks++; if (mism != 0) begin errors++; $display("FAIL glitch_model got=%0d bad cycles (first %0d) exp=0", mism, first_mism); end
  endtask
`endif

  task automatic test_reset_mid();
    do_reset();
    apply(pat[0], 8);
    for (int s = 1; s <= 7; s++) apply(pat[s % 4], 6);
    checks++; if (o_position !== 16'sd7) begin errors++; $display("FAIL mid_preload got=%0d exp=7", o_position); end
    phases = pat[0];
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (o_position !== 16'sd0 || o_synced !== 1'b0 || o_step_dir !== 1'b0 || o_phase_idx !== 2'd0 || o_step_pulse !== 1'b0 || o_fault !== 1'b0)
      begin errors++; $display("FAIL mid_reset got=pos%0d s%b d%b i%0d p%b f%b exp=all 0", o_position, o_synced, o_step_dir, o_phase_idx, o_step_pulse, o_fault); end
    d_pulses = 0;
    apply(pat[0], 8);
    checks++; if (o_synced !== 1'b1 || d_pulses != 0 || o_position !== 16'sd0) begin errors++; $display("FAIL mid_resync got=s%b pulses%0d pos%0d exp=s1 pulses0 pos0", o_synced, d_pulses, o_position); end
    apply(pat[1], 8);
    checks++; if (o_position !== 16'sd1 || d_pulses != 1) begin errors++; $display("FAIL mid_step got=pos%0d pulses%0d exp=pos1 pulses1", o_position, d_pulses); end
  endtask

  task automatic test_random();
    int r;
    int hold;
    do_reset();
    for (int seg = 0; seg < 400; seg++) begin
      r = $urandom_range(0, 9);
      if (r < 4)       phases = pat[(m_idx + 1) % 4];
      else if (r < 7)  phases = pat[(m_idx + 3) % 4];
      else if (r == 7) phases = pat[m_idx];
      else if (r == 8) phases = pat[(m_idx + 2) % 4];
      else             phases = 4'($urandom_range(0, 15));
      hold = $urandom_range(1, 6);
      for (int h = 0; h < hold; h++) begin
        zero = ($urandom_range(0, 19) == 0);
        clr  = ($urandom_range(0, 3) == 0);
        tick();
      end
    end
    zero = 1'b0; clr = 1'b0;
    checks++; if (mism != 0) begin errors++; $display("FAIL random_model got=%0d bad cycles (first %0d) exp=0", mism, first_mism); end
    checks++; if (o_position !== 16'(m_pos)) begin errors++; $display("FAIL random_pos got=%0d exp=%0d", o_position, m_pos); end
    checks++; if (o_synced !== (m_state == M_TRACK)) begin errors++; $display("FAIL random_synced got=%b exp=%0d", o_synced, m_state == M_TRACK); end
  endtask

  initial begin
    rst = 1'b1; phases = 4'b0000; clr = 1'b0; zero = 1'b0;
    test_reset();
    test_forward();
    test_reverse();
    test_fault();
    test_latency();
`ifndef STEP_DECODER_GLITCH_FILTER_EN
    test_wrap();
`else
    test_glitch();
`endif
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
